stream_rr_arbiter: RTL and testbench

//  Shares one downstream valid/ready stream between NUM_IN upstream requesters using round-robin arbitration.

---
 rtl/stream_rr_arbiter.sv | 87 ++++++++
 tb/tb_stream_rr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N:1 valid/ready stream arbiter with optional packet lock and a registered output stage
module stream_rr_arbiter #(
    parameter  int NUM_IN       = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  bit LOCK_ON_LAST = 1'b1,
    localparam int IDX_W        = $clog2(NUM_IN) > 1 ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_IN-1:0]            data_in_last,
    input  logic [NUM_IN-1:0]            data_in_valid,
    output logic [NUM_IN-1:0]            data_in_ready,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_out_last,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [IDX_W-1:0]             data_out_src
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, src_q, src_d;
    logic [IDX_W-1:0]      sel, grant_idx;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d, valid_q, valid_d;
    logic                  found, load_en, accept, beat_last;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v >= NUM_IN ? v - NUM_IN : v);
    endfunction

    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        // descending scan so the requester closest to rr_ptr is the one left in sel
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (data_in_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
                sel   = wrap_idx(int'(rr_ptr_q) + k);
                found = 1'b1;
            end
        end
        grant_idx     = (state_q == LOCKED) ? lock_idx_q : sel;
        load_en       = !valid_q || data_out_ready;
        data_in_ready = ((state_q == LOCKED || found) && load_en) ? NUM_IN'(1) << grant_idx : '0;
        accept        = |(data_in_ready & data_in_valid);
        beat_last     = data_in_last[grant_idx];
        valid_d       = load_en ? accept : valid_q;
        data_d        = accept ? data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH] : data_q;
        last_d        = accept ? beat_last : last_q;
        src_d         = accept ? grant_idx : src_q;
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_idx_d    = lock_idx_q;
        if (accept && state_q == IDLE && LOCK_ON_LAST && !beat_last) begin
            state_d    = LOCKED;
            lock_idx_d = sel;
        end else if (accept && (state_q == IDLE || beat_last)) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_idx(int'(grant_idx) + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            src_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            src_q      <= src_d;
            data_q     <= data_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_last  = last_q;
    assign data_out_valid = valid_q;
    assign data_out_src   = src_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: three arbiter configurations (4/lock, 3/no-lock, 3/lock) against an integer reference model
module tb_stream_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit in_v [3][4];
    bit in_l [3][4];
    bit o_rdy[3];
    int seq [3][4];
    int oseq[3][4];
    int wait_pk[3][4];
    int mv[3], md[3], ml[3], ms[3], ptr[3], owner[3];
    int checks = 0;
    int errors = 0;
    int exp2a[5] = '{0, 1, 1, 1, 2};
    int exp2b[5] = '{2, 0, 1, 2, 0};
    logic [31:0] held;

    logic [127:0] a_data;
    logic [3:0]   a_last, a_valid, a_ready;
    logic [31:0]  a_dout;
    logic         a_olast, a_ovalid;
    logic [1:0]   a_src;
    logic [95:0]  b_data, c_data;
    logic [2:0]   b_last, b_valid, b_ready, c_last, c_valid, c_ready;
    logic [31:0]  b_dout, c_dout;
    logic         b_olast, b_ovalid, c_olast, c_ovalid;
    logic [1:0]   b_src, c_src;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_valid[i]          = in_v[0][i];
            a_last[i]           = in_l[0][i];
            a_data[i*32 +: 32]  = (i << 24) | seq[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            b_valid[i]          = in_v[1][i];
            b_last[i]           = in_l[1][i];
            b_data[i*32 +: 32]  = (i << 24) | seq[1][i];
            c_valid[i]          = in_v[2][i];
            c_last[i]           = in_l[2][i];
            c_data[i*32 +: 32]  = (i << 24) | seq[2][i];
        end
    end

    stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data), .data_in_last(a_last),
        .data_in_valid(a_valid), .data_in_ready(a_ready), .data_out(a_dout),
        .data_out_last(a_olast), .data_out_valid(a_ovalid), .data_out_ready(o_rdy[0]),
        .data_out_src(a_src));
    stream_rr_arbiter #(.NUM_IN(3), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data), .data_in_last(b_last),
        .data_in_valid(b_valid), .data_in_ready(b_ready), .data_out(b_dout),
        .data_out_last(b_olast), .data_out_valid(b_ovalid), .data_out_ready(o_rdy[1]),
        .data_out_src(b_src));
    stream_rr_arbiter #(.NUM_IN(3), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_data), .data_in_last(c_last),
        .data_in_valid(c_valid), .data_in_ready(c_ready), .data_out(c_dout),
        .data_out_last(c_olast), .data_out_valid(c_ovalid), .data_out_ready(o_rdy[2]),
        .data_out_src(c_src));

    function automatic int nn(input int m);
        return m == 0 ? 4 : 3;
    endfunction

    function automatic bit lk(input int m);
        return m != 1;
    endfunction

    // field 0 ready, 1 valid, 2 data, 3 last, 4 src
    function automatic logic [31:0] obs(input int m, input int f);
        logic [31:0] r[5];
        if (m == 0) r = '{32'(a_ready), 32'(a_ovalid), a_dout, 32'(a_olast), 32'(a_src)};
        else if (m == 1) r = '{32'(b_ready), 32'(b_ovalid), b_dout, 32'(b_olast), 32'(b_src)};
        else r = '{32'(c_ready), 32'(c_ovalid), c_dout, 32'(c_olast), 32'(c_src)};
        return r[f];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 3; m++) begin
            mv[m] = 0; md[m] = 0; ml[m] = 0; ms[m] = 0; ptr[m] = 0; owner[m] = -1;
            for (int i = 0; i < 4; i++) begin
                oseq[m][i]    = seq[m][i];
                wait_pk[m][i] = 0;
            end
        end
    endtask

    task automatic set_in(input bit v, input bit l, input bit r);
        for (int m = 0; m < 3; m++) begin
            o_rdy[m] = r;
            for (int i = 0; i < 4; i++) begin
                in_v[m][i] = v && i < nn(m);
                in_l[m][i] = l;
            end
        end
    endtask

    // inputs are set at a falling edge; check, then advance one clock and update the model
    task automatic cyc();
        int g[3];
        bit ld[3], acc[3], lst[3];
        int n, s;
        #1;
        for (int m = 0; m < 3; m++) begin
            n     = nn(m);
            ld[m] = (mv[m] == 0) || o_rdy[m];
            g[m]  = owner[m];
            for (int k = 0; k < n; k++)
                if (g[m] < 0 && in_v[m][(ptr[m] + k) % n]) g[m] = (ptr[m] + k) % n;
            acc[m] = (g[m] >= 0) ? (ld[m] && in_v[m][g[m]]) : 1'b0;
            lst[m] = (g[m] >= 0) ? in_l[m][g[m]] : 1'b0;
            chk($sformatf("ready%0d", m), obs(m, 0), (g[m] >= 0 && ld[m]) ? 32'(1 << g[m]) : 32'd0);
            chk($sformatf("valid%0d", m), obs(m, 1), 32'(mv[m]));
            chk($sformatf("data%0d", m), obs(m, 2), 32'(md[m]));
            chk($sformatf("last%0d", m), obs(m, 3), 32'(ml[m]));
            chk($sformatf("src%0d", m), obs(m, 4), 32'(ms[m]));
            if (obs(m, 1) === 32'd1 && o_rdy[m] && obs(m, 4) < 32'(n)) begin
                s = int'(obs(m, 4));
                chk($sformatf("order%0d_%0d", m, s), obs(m, 2) & 32'h00ff_ffff, 32'(oseq[m][s]));
                oseq[m][s]++;
            end
        end
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            n = nn(m);
            if (ld[m]) mv[m] = acc[m];
            if (acc[m]) begin
                md[m] = (g[m] << 24) | seq[m][g[m]];
                ml[m] = lst[m];
                ms[m] = g[m];
                if (owner[m] < 0) begin
                    if (lk(m) && !lst[m]) owner[m] = g[m];
                    else ptr[m] = (g[m] + 1) % n;
                end else if (lst[m]) begin
                    owner[m] = -1;
                    ptr[m]   = (g[m] + 1) % n;
                end
                if (lst[m] || !lk(m))
                    for (int i = 0; i < n; i++)
                        if (i != g[m] && in_v[m][i]) begin
                            wait_pk[m][i]++;
                            chk($sformatf("starve%0d_%0d", m, i), 32'(wait_pk[m][i] <= n), 32'd1);
                        end
                wait_pk[m][g[m]] = 0;
                seq[m][g[m]]++;
            end
            for (int i = 0; i < n; i++) if (!in_v[m][i]) wait_pk[m][i] = 0;
        end
    endtask

    initial begin
        for (int m = 0; m < 3; m++) for (int i = 0; i < 4; i++) seq[m][i] = 0;
        set_in(1'b0, 1'b0, 1'b1);
        reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();
        // every requester streaming single-beat packets: strict rotation
        set_in(1'b1, 1'b1, 1'b1);
        for (int t = 0; t < 8; t++) begin
            cyc();
            chk("t1_src", obs(0, 4), 32'(t % 4));
            chk("t1_valid", obs(0, 1), 32'd1);
        end
        // requester 1 sends a 3-beat packet between single-beat neighbours
        for (int t = 0; t < 5; t++) begin
            for (int m = 0; m < 3; m++) begin
                for (int i = 0; i < 4; i++) in_v[m][i] = i < 3;
                in_l[m][0] = 1'b1;
                in_l[m][2] = 1'b1;
                in_l[m][1] = (t == 3);
            end
            cyc();
            chk("t2_src_lock", obs(0, 4), 32'(exp2a[t]));
            chk("t3_src_nolock", obs(1, 4), 32'(exp2b[t]));
        end
        // backpressure holds the output and blocks every requester
        set_in(1'b1, 1'b1, 1'b1);
        cyc();
        set_in(1'b1, 1'b1, 1'b0);
        held = obs(0, 2);
        for (int t = 0; t < 5; t++) begin
            cyc();
            chk("t4_hold", obs(0, 2), held);
            chk("t4_ready", obs(0, 0), 32'd0);
        end
        set_in(1'b1, 1'b1, 1'b1);
        repeat (4) cyc();
        // reset in the middle of a locked packet from the highest requester
        set_in(1'b0, 1'b0, 1'b1);
        repeat (2) cyc();
        for (int m = 0; m < 3; m++) in_v[m][nn(m) - 1] = 1'b1;
        repeat (2) cyc();
        chk("t5_pre_valid", obs(0, 1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) chk($sformatf("t5_async%0d", m), obs(m, 1), 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b1);
        cyc();
        for (int m = 0; m < 3; m++) chk($sformatf("t5_restart%0d", m), obs(m, 4), 32'd0);
        // random traffic and backpressure
        for (int t = 0; t < 10000; t++) begin
            for (int m = 0; m < 3; m++) begin
                o_rdy[m] = $urandom_range(0, 3) != 0;
                for (int i = 0; i < 4; i++) begin
                    in_v[m][i] = i < nn(m) && $urandom_range(0, 3) != 0;
                    in_l[m][i] = $urandom_range(0, 2) == 0;
                end
            end
            cyc();
        end
        set_in(1'b0, 1'b0, 1'b1);
        repeat (3) cyc();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < nn(m); i++)
                chk($sformatf("drain%0d_%0d", m, i), 32'(oseq[m][i]), 32'(seq[m][i]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
